// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared types and sizing helpers for the shift-add multiplier
package multiplier_pkg;

  // Controller states of the sequential multiplier
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default operand width used by the top level
  localparam int MULT_N_DEFAULT = 5;

  // Number of BCD digits that always covers a 2n-bit binary value
  function automatic int bcd_digits(input int n);
    return (2 * n / 3) + 1;
  endfunction

  // Width of an iteration counter able to hold the value n
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multiplier_bin2bcd.sv
// rtl/multiplier_bin2bcd.sv - combinational double-dabble binary to packed BCD converter
module multiplier_bin2bcd #(
  parameter int W = 10,
  parameter int D = 4
) (
  input  logic [W-1:0]   bin,
  output logic [4*D-1:0] bcd
);

  // Working register: BCD digits sit above the binary field and fill as bits shift in
  logic [4*D+W-1:0] scratch;

  // Shift-add-3: before each left shift, bump every digit that is 5 or more by 3
  always_comb begin
    scratch = '0;
    scratch[W-1:0] = bin;
    for (int i = 0; i < W; i++) begin
      for (int d = 0; d < D; d++) begin
        if (scratch[W + 4*d +: 4] >= 4'd5) begin
          scratch[W + 4*d +: 4] = scratch[W + 4*d +: 4] + 4'd3;
        end
      end
      scratch = scratch << 1;
    end
  end

  assign bcd = scratch[4*D+W-1 -: 4*D];

endmodule

// File: rtl/multiplier.sv
// rtl/multiplier.sv - unsigned sequential shift-add multiplier with BCD readout
module multiplier
  import multiplier_pkg::*;
#(
  parameter int N = MULT_N_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N-1:0]                 a_in,
  input  logic [N-1:0]                 b_in,
  input  logic                         start,
  output logic [2*N-1:0]               out,
  output logic                         finish,
  output logic [4*bcd_digits(N)-1:0]   bcd
);

  localparam int D  = bcd_digits(N);
  localparam int CW = cnt_width(N);
  // Counter value at which the current edge performs the final iteration
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] out_q, out_d;
  logic           finish_q, finish_d;

  // One shift-add step: conditional add into the upper half, then shift the pair right
  logic [N:0]   step_sum;
  logic [N-1:0] step_acc;
  logic [N-1:0] step_mplier;

  assign step_sum    = {1'b0, acc_q} + ({(N+1){mplier_q[0]}} & {1'b0, mcand_q});
  assign step_acc    = step_sum[N:1];
  assign step_mplier = {step_sum[0], mplier_q[N-1:1]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start low always returns to IDLE, start high advances toward DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (!start) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end
      DONE: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; start low reloads operands and clears the partial result
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    finish_d = finish_q;
    if (!start) begin
      mcand_d  = a_in;
      mplier_d = b_in;
      acc_d    = '0;
      cnt_d    = '0;
      finish_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          acc_d    = step_acc;
          mplier_d = step_mplier;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            out_d    = {step_acc, step_mplier};
            finish_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      finish_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      finish_q <= finish_d;
    end
  end

  assign out    = out_q;
  assign finish = finish_q;

  multiplier_bin2bcd #(
    .W (2*N),
    .D (D)
  ) u_bin2bcd (
    .bin (out_q),
    .bcd (bcd)
  );

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - self-checking bench for the shift-add multiplier
module tb_multiplier;

  localparam int N = 5;
  localparam int D = (2 * N / 3) + 1;

  logic             clk;
  logic             reset;
  logic [N-1:0]     a_in;
  logic [N-1:0]     b_in;
  logic             start;
  logic [2*N-1:0]   out;
  logic             finish;
  logic [4*D-1:0]   bcd;

  int checks;
  int failures;
  int exp_out;

  multiplier #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .a_in   (a_in),
    .b_in   (b_in),
    .start  (start),
    .out    (out),
    .finish (finish),
    .bcd    (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits of v, least significant digit in the lowest nibble
  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int exp_o, input int exp_f);
    check({tag, ".out"}, int'(out), exp_o);
    check({tag, ".finish"}, int'(finish), exp_f);
    check({tag, ".bcd"}, int'(bcd), int'(to_bcd(exp_o)));
  endtask

  // Load operands with start low, then run N edges with start high and verify the product
  task automatic run_mult(input int a, input int b, input string tag);
    a_in  = N'(a);
    b_in  = N'(b);
    start = 1'b0;
    step();
    check({tag, ".drop_finish"}, int'(finish), 0);
    check({tag, ".drop_out"}, int'(out), exp_out);
    step();
    start = 1'b1;
    for (int i = 1; i < N; i++) begin
      step();
      check({tag, ".run_finish"}, int'(finish), 0);
      check({tag, ".run_out"}, int'(out), exp_out);
    end
    step();
    exp_out = a * b;
    check_outputs({tag, ".done"}, exp_out, 1);
    step();
    check_outputs({tag, ".hold"}, exp_out, 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_out  = 0;
    reset    = 1'b0;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    step();
    check_outputs("reset", 0, 0);
    reset = 1'b1;
    step();
    step();
    check_outputs("post_reset", 0, 0);

    run_mult(26, 30, "m26x30");
    run_mult(13, 13, "m13x13");
    run_mult(31, 31, "m31x31");
    run_mult(0, 31, "m0x31");
    run_mult(1, 1, "m1x1");
    run_mult(31, 0, "m31x0");

    // Abort after two edges of start: no completion, previous product kept
    a_in  = N'(20);
    b_in  = N'(21);
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    step();
    check_outputs("abort", exp_out, 0);
    step();
    check_outputs("abort_idle", exp_out, 0);
    run_mult(7, 9, "m7x9");

    for (int k = 0; k < 10; k++) begin
      run_mult(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), "rand");
    end

    // Asynchronous reset in the middle of a run, between clock edges
    a_in  = N'(11);
    b_in  = N'(12);
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    exp_out = 0;
    check_outputs("async_reset", 0, 0);
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_outputs("after_reset", 0, 0);
    run_mult(5, 6, "m5x6");

    start = 1'b0;
    step();
    check_outputs("final_drop", 30, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Unsigned sequential shift-add multiplier for two N-bit operands.
- Produces a 2N-bit product after N clock iterations, with a completion flag.
- Also outputs a combinational packed-BCD rendering of the product for display or readout logic.
- Sits as a leaf arithmetic block driven by a level-sensitive start from a controller.

Parameters:
N, 5, operand width in bits (N >= 2); product width is 2N; BCD digit count D = (2N/3)+1 (integer division).

Ports:
clk  input  1  single clock, rising-edge active
reset  input  1  asynchronous, active-low reset (asserted when 0)
a_in  input  N  multiplicand, unsigned
b_in  input  N  multiplier, unsigned
start  input  1  level: 0 = idle/load, 1 = run/hold
out  output  2N  registered product of last completed multiplication
finish  output  1  high while a completed result is held and start remains 1
bcd  output  4*D  packed BCD of out, digit 0 in bits [3:0], combinational

Behaviour:
- Reset (reset=0, async): state=IDLE, out=0, finish=0, all internal registers cleared; bcd therefore 0.
- States: IDLE, RUN, DONE.
- IDLE, start=0, each clk edge:
  - capture a_in and b_in into internal registers;
  - clear the accumulator and iteration counter;
  - finish=0.
- IDLE, start=1 at a clk edge:
  - go to RUN;
  - perform iteration 1 using the operands captured at the previous edge (operands are not re-sampled once start=1).
- RUN iteration: one shift-add step per edge.
  - If the current multiplier LSB=1, add the multiplicand into the upper accumulator half (N+1-bit add, carry kept).
  - Shift the {accumulator, multiplier} pair right by one.
  - Counter increments.
- On the edge performing iteration N:
  - out <= full 2N-bit product;
  - finish <= 1;
  - state <= DONE.
  - Latency: finish and out are valid after exactly N rising edges with start=1.
- DONE, start=1: hold out and finish=1; no further arithmetic.
- DONE, start=0 at an edge: finish <= 0; state <= IDLE (operands re-captured that edge); out keeps the last product.
- RUN, start=0 at an edge (abort): state <= IDLE, finish stays 0, out unchanged, partial result discarded.
- Reset asserted mid-RUN or in DONE: immediate return to the reset values above.
- Arithmetic is unsigned and cannot overflow: (2^N-1)^2 < 2^(2N).
- bcd is the double-dabble (shift-add-3) conversion of out.
  - D digits always suffice for 2N bits.
  - Unused upper digits are 0.
  - It changes in the same cycle out changes.
- out changes only on completion or reset; it is not disturbed during RUN.

Decomposition:
- Shared package contents:
  - state enum {IDLE, RUN, DONE};
  - function bcd_digits(n) = (2n/3)+1;
  - counter width constant $clog2(N+1).
- One natural sub-module: bin2bcd.
  - Purely combinational double-dabble.
  - Parameters: binary width W=2N and digit count D.
  - Input: bin[W-1:0]. Output: bcd[4D-1:0].
  - Instantiated once, on out.

Test Plan:
- Reset then release with start=0 → out=0, finish=0, bcd=0x0000.
- N=5, a=26, b=30, start=0 for 2 cycles, then start=1 → finish rises after the 5th edge with start=1; out=780, bcd=0x0780. Both hold while start=1.
- Drop start, load a=13, b=13, start=0 for 2 cycles, then start=1 → finish drops on the first start=0 edge and out stays 780 until completion. Then out=169, bcd=0x0169 after 5 edges.
- Boundary operands:
  - a=31, b=31 → out=961, bcd=0x0961;
  - a=0, b=31 → out=0;
  - a=1, b=1 → out=1.
- Abort: start=1 for 2 edges, then 0 → finish never asserts and out keeps its previous value. The next full run with a=7, b=9 gives out=63.
- Async reset (reset=0) pulsed mid-RUN between clock edges → out=0 and finish=0 immediately, before the next edge; the FSM restarts from IDLE.
